wb_commit_rf: RTL and testbench
===============================

Name: wb_commit_rf

Overview:
Parametrised write-back/commit stage for the three-stage RISC-V core: formats load data, writes the integer register file, forwards write-back results to two decode read ports, and squashes a configurable number of post-branch slots. Unlike the fixed-latency version, it accepts variable-latency load responses via a valid flag. It holds early responses while the pipe is stalled, and counts retired instructions.

Parameters:
XLEN, 32, datapath width; 32 or 64 only
NREGS, 32, architectural registers; x0 hard-wired zero
NOP_SLOTS, 2, slots squashed after a taken branch (1..7)
CNT_W, 64, retired-instruction counter width
AW, log2(XLEN/8), byte-offset width of load address

Ports:
clk  in  1  clock
reset  in  1  async active-low reset
stall_in  in  1  execute/fetch stall request
wb_valid  in  1  WB slot holds an instruction
wb_we  in  1  instruction writes rd
wb_is_load  in  1  instruction is a load
wb_branch  in  1  taken branch/jump in WB slot
wb_rd  in  log2(NREGS)  destination register
wb_funct3  in  3  load type
wb_addr_lo  in  AW  load byte offset
wb_result  in  XLEN  ALU result
dmem_rvalid  in  1  load response valid (one-cycle pulse)
dmem_rdata  in  XLEN  load response data
rs1_sel, rs2_sel  in  log2(NREGS)  decode read selects
rs1_data, rs2_data  out  XLEN  forwarded read data
wb_stall  out  1  freeze upstream stages
wb_squash  out  1  current WB slot is squashed
load_misaligned  out  1  misaligned load in WB (combinational)
instret  out  CNT_W  retired count

Behaviour:
- Clock is clk. Reset is asynchronous and active-low.
- Reset values: regs all 0; FSM IDLE; squash counter 0; hold register 0; instret 0. Outputs derived from these: wb_stall = stall_in; wb_squash = 0.
- advance = !stall_in && !wb_stall.
- live = wb_valid && !wb_squash.
- load_act = live && wb_is_load && !load_misaligned.
- FSM states are IDLE, WAIT, HELD:
  - IDLE: if load_act and no dmem_rvalid, go to WAIT. If load_act and dmem_rvalid and stall_in, capture dmem_rdata into hold and go to HELD.
  - WAIT: on dmem_rvalid, go to IDLE if advance would be 1, otherwise capture and go to HELD.
  - HELD: go to IDLE on advance.
  - dmem_rvalid in IDLE without load_act is ignored.
- wb_stall = stall_in || (load_act && !(dmem_rvalid || state==HELD)).
- Load data source: hold in HELD, otherwise dmem_rdata.
- Load formatting by wb_funct3:
  - 000 LB: sign-extend byte at offset.
  - 001 LH: sign-extend halfword at offset[AW-1:1].
  - 010 LW: word, sign-extended when XLEN=64.
  - 011 LD: XLEN=64 only.
  - 100 LBU, 101 LHU, 110 LWU (LWU XLEN=64 only): zero-extended forms.
  - Any other funct3 yields 0.
- load_misaligned: LH/LHU with offset[0]!=0; LW/LWU with offset[1:0]!=0; LD with offset!=0. A misaligned load suppresses the write and does not stall. It still retires.
- wdata = wb_is_load ? formatted : wb_result.
- Write occurs on advance && live && wb_we && wb_rd!=0 && !load_misaligned.
- Forwarding: rsN_data = 0 if rsN_sel==0. Else wdata if (live && wb_we && !load_misaligned && wb_rd==rsN_sel). Else regs[rsN_sel]. Data is only meaningful while wb_stall is 0.
- Squash counter:
  - On advance && live && wb_branch, load NOP_SLOTS.
  - Else on advance with counter nonzero, decrement.
  - wb_squash = counter != 0.
  - A branch in a squashed slot is ignored.
- instret increments on advance && live and wraps modulo 2^CNT_W.
- Reset mid-WAIT/HELD returns to IDLE. A late dmem_rvalid after reset is dropped.

Decomposition:
- Shared core package holds the funct3 load encodings (LB..LWU), the FSM state enum, and the XLEN legality check (elaboration error otherwise).
- Sub-module load_align (combinational formatter plus misalign detect), parametrised by XLEN.

Test Plan:
1. LW at offset 0, dmem_rvalid same cycle, rd=x5, dmem_rdata=0xDEADBEEF -> x5=0xDEADBEEF, wb_stall never high, instret +1.
2. LB at offset 3, rvalid three cycles late, dmem_rdata=0x80xxxxxx -> wb_stall high exactly 3 cycles, write 0xFFFFFF80.
3. rvalid arrives while stall_in=1 for 2 cycles, then drops, then stall_in releases -> FSM in HELD, the held value is written on release, no lost data.
4. Taken branch with NOP_SLOTS=3, followed by 3 ALU writes to x7 and a 4th write to x7=0x11 -> only 0x11 written, instret counts branch plus 1.
5. LH at offset 1 -> load_misaligned=1, no write, no stall. rd=x0 ALU write of 0x55 -> x0 reads 0.
6. Reset asserted in WAIT, then a stray rvalid -> FSM IDLE, all regs 0, no write; forwarding: rs1_sel=wb_rd=x9 with result 0x1234 -> rs1_data=0x1234 same cycle.

Source files
------------

// File: rtl/wb_commit_rf_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_rf_pkg
// Shared definitions for the write-back/commit stage:
//   - RISC-V load funct3 encodings (LB..LWU)
//   - load-response FSM state enum
//   - squash counter width
//   - datapath-width legality check used at elaboration time
// -----------------------------------------------------------------------------
package wb_commit_rf_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Wide enough for the largest legal NOP_SLOTS value (7).
  localparam int SQ_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no load response outstanding
    ST_WAIT = 2'd1,  // load in WB, response not yet arrived
    ST_HELD = 2'd2   // response arrived while stalled, parked in hold
  } wb_state_e;

  function automatic logic xlen_is_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/wb_commit_rf_load_align.sv
// -----------------------------------------------------------------------------
// wb_commit_rf_load_align
// Purely combinational load formatter and misalignment detector.
//   funct3_i      : load type (LB/LH/LW/LD/LBU/LHU/LWU)
//   addr_lo_i     : byte offset of the load within the XLEN-wide word
//   rdata_i       : raw XLEN-wide load response
//   data_o        : selected, sign/zero-extended load value (0 for illegal types)
//   misaligned_o  : access crosses its natural alignment
// LD and LWU only exist for XLEN=64; on XLEN=32 they format to 0 and never
// flag misalignment.
// -----------------------------------------------------------------------------
module wb_commit_rf_load_align
  import wb_commit_rf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = $clog2(XLEN / 8)
) (
  input  logic [2:0]      funct3_i,
  input  logic [AW-1:0]   addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o
);

  logic [AW-1:0]      half_off_s;
  logic [AW-1:0]      word_off_s;
  logic [7:0]         byte_v_s;
  logic [15:0]        half_v_s;
  logic [31:0]        word_v_s;
  logic signed [7:0]  byte_sgn_s;
  logic signed [15:0] half_sgn_s;
  logic signed [31:0] word_sgn_s;

  // Halfword/word lanes ignore the low offset bits; misalignment is flagged separately.
  assign half_off_s = addr_lo_i & ~(AW'(1'b1));
  assign word_off_s = addr_lo_i & ~(AW'(2'b11));

  assign byte_v_s = 8'(rdata_i >> {addr_lo_i, 3'b000});
  assign half_v_s = 16'(rdata_i >> {half_off_s, 3'b000});
  assign word_v_s = 32'(rdata_i >> {word_off_s, 3'b000});

  assign byte_sgn_s = byte_v_s;
  assign half_sgn_s = half_v_s;
  assign word_sgn_s = word_v_s;

  // Format the selected lane according to the load type.
  always_comb begin
    data_o = {XLEN{1'b0}};
    case (funct3_i)
      F3_LB:  data_o = XLEN'(byte_sgn_s);
      F3_LH:  data_o = XLEN'(half_sgn_s);
      F3_LW:  data_o = XLEN'(word_sgn_s);
      F3_LD: begin
        if (XLEN == 64) begin
          data_o = rdata_i;
        end else begin
          data_o = {XLEN{1'b0}};
        end
      end
      F3_LBU: data_o = XLEN'(byte_v_s);
      F3_LHU: data_o = XLEN'(half_v_s);
      F3_LWU: begin
        if (XLEN == 64) begin
          data_o = XLEN'(word_v_s);
        end else begin
          data_o = {XLEN{1'b0}};
        end
      end
      default: data_o = {XLEN{1'b0}};
    endcase
  end

  // Detect accesses that are not naturally aligned.
  always_comb begin
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LH, F3_LHU: misaligned_o = addr_lo_i[0];
      F3_LW:         misaligned_o = (addr_lo_i[1:0] != 2'b00);
      F3_LWU: begin
        if (XLEN == 64) begin
          misaligned_o = (addr_lo_i[1:0] != 2'b00);
        end else begin
          misaligned_o = 1'b0;
        end
      end
      F3_LD: begin
        if (XLEN == 64) begin
          misaligned_o = (addr_lo_i != {AW{1'b0}});
        end else begin
          misaligned_o = 1'b0;
        end
      end
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_commit_rf.sv
// -----------------------------------------------------------------------------
// wb_commit_rf
// Write-back/commit stage: formats load data, writes the integer register
// file, forwards the WB result to the two decode read ports, squashes
// NOP_SLOTS slots after a taken branch and counts retired instructions.
// Load responses may arrive with variable latency (dmem_rvalid pulse); a
// response that arrives while the pipe is stalled is parked in a hold register.
//
// Ports:
//   clk, reset (async, active-low)
//   stall_in                  upstream stall request
//   wb_valid/we/is_load/branch, wb_rd, wb_funct3, wb_addr_lo, wb_result
//                             instruction currently in WB
//   dmem_rvalid, dmem_rdata   load response
//   rs1_sel/rs2_sel -> rs1_data/rs2_data  forwarded decode reads
//   wb_stall, wb_squash, load_misaligned, instret
// -----------------------------------------------------------------------------
module wb_commit_rf
  import wb_commit_rf_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NOP_SLOTS = 2,
  parameter int CNT_W     = 64,
  parameter int AW        = $clog2(XLEN / 8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall_in,
  input  logic                     wb_valid,
  input  logic                     wb_we,
  input  logic                     wb_is_load,
  input  logic                     wb_branch,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [2:0]               wb_funct3,
  input  logic [AW-1:0]            wb_addr_lo,
  input  logic [XLEN-1:0]          wb_result,
  input  logic                     dmem_rvalid,
  input  logic [XLEN-1:0]          dmem_rdata,
  input  logic [$clog2(NREGS)-1:0] rs1_sel,
  input  logic [$clog2(NREGS)-1:0] rs2_sel,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     wb_stall,
  output logic                     wb_squash,
  output logic                     load_misaligned,
  output logic [CNT_W-1:0]         instret
);

  localparam int RW = $clog2(NREGS);

  if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
    $error("wb_commit_rf: XLEN must be 32 or 64");
  end
  if ((NOP_SLOTS < 1) || (NOP_SLOTS > 7)) begin : g_bad_nop_slots
    $error("wb_commit_rf: NOP_SLOTS must be within 1..7");
  end

  wb_state_e         state_q;
  logic [XLEN-1:0]   hold_q;
  logic [SQ_W-1:0]   squash_q;
  logic [SQ_W-1:0]   squash_d;
  logic [CNT_W-1:0]  instret_q;
  logic [CNT_W-1:0]  instret_d;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic              advance_s;
  logic              live_s;
  logic              load_act_s;
  logic              align_mis_s;
  logic [XLEN-1:0]   load_src_s;
  logic [XLEN-1:0]   fmt_data_s;
  logic [XLEN-1:0]   wdata_s;
  logic              fwd_ok_s;
  logic              wr_en_s;

  assign wb_squash       = (squash_q != {SQ_W{1'b0}});
  assign live_s          = wb_valid && !wb_squash;
  assign load_misaligned = wb_valid && wb_is_load && align_mis_s;
  assign load_act_s      = live_s && wb_is_load && !load_misaligned;

  // A live load stalls until its response is visible (now, or parked in hold).
  assign wb_stall  = stall_in || (load_act_s && !(dmem_rvalid || (state_q == ST_HELD)));
  assign advance_s = !stall_in && !wb_stall;

  assign load_src_s = (state_q == ST_HELD) ? hold_q : dmem_rdata;

  wb_commit_rf_load_align #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_load_align (
    .funct3_i     (wb_funct3),
    .addr_lo_i    (wb_addr_lo),
    .rdata_i      (load_src_s),
    .data_o       (fmt_data_s),
    .misaligned_o (align_mis_s)
  );

  assign wdata_s  = wb_is_load ? fmt_data_s : wb_result;
  assign fwd_ok_s = live_s && wb_we && !load_misaligned;
  assign wr_en_s  = advance_s && fwd_ok_s && (wb_rd != {RW{1'b0}});

  // Load-response FSM: tracks outstanding responses and parks early ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_act_s && !dmem_rvalid) begin
            state_q <= ST_WAIT;
          end else if (load_act_s && dmem_rvalid && stall_in) begin
            hold_q  <= dmem_rdata;
            state_q <= ST_HELD;
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            if (advance_s) begin
              state_q <= ST_IDLE;
            end else begin
              hold_q  <= dmem_rdata;
              state_q <= ST_HELD;
            end
          end
        end
        ST_HELD: begin
          if (advance_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Next-state for the squash counter and retired-instruction counter.
  always_comb begin
    squash_d  = squash_q;
    instret_d = instret_q;
    // A branch in a squashed slot is not live, so it cannot reload the counter.
    if (advance_s && live_s && wb_branch) begin
      squash_d = SQ_W'(NOP_SLOTS);
    end else if (advance_s && wb_squash) begin
      squash_d = squash_q - {{(SQ_W-1){1'b0}}, 1'b1};
    end else begin
      squash_d = squash_q;
    end
    if (advance_s && live_s) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash_q  <= {SQ_W{1'b0}};
      instret_q <= {CNT_W{1'b0}};
    end else begin
      squash_q  <= squash_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  // Integer register file; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_q[wb_rd] <= wdata_s;
    end
  end

  // Decode read port 1 with WB bypass.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (rs1_sel == {RW{1'b0}}) begin
      rs1_data = {XLEN{1'b0}};
    end else if (fwd_ok_s && (wb_rd == rs1_sel)) begin
      rs1_data = wdata_s;
    end else begin
      rs1_data = regs_q[rs1_sel];
    end
  end

  // Decode read port 2 with WB bypass.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (rs2_sel == {RW{1'b0}}) begin
      rs2_data = {XLEN{1'b0}};
    end else if (fwd_ok_s && (wb_rd == rs2_sel)) begin
      rs2_data = wdata_s;
    end else begin
      rs2_data = regs_q[rs2_sel];
    end
  end

endmodule

// File: tb/tb_wb_commit_rf.sv
module tb_wb_commit_rf;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        wb_valid;
  logic        wb_we;
  logic        wb_is_load;
  logic        wb_branch;
  logic [4:0]  wb_rd;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_lo;
  logic [31:0] wb_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_stall;
  logic        wb_squash;
  logic        load_misaligned;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  wb_commit_rf #(
    .XLEN      (32),
    .NREGS     (32),
    .NOP_SLOTS (3),
    .CNT_W     (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .wb_valid        (wb_valid),
    .wb_we           (wb_we),
    .wb_is_load      (wb_is_load),
    .wb_branch       (wb_branch),
    .wb_rd           (wb_rd),
    .wb_funct3       (wb_funct3),
    .wb_addr_lo      (wb_addr_lo),
    .wb_result       (wb_result),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .rs1_sel         (rs1_sel),
    .rs2_sel         (rs2_sel),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .wb_stall        (wb_stall),
    .wb_squash       (wb_squash),
    .load_misaligned (load_misaligned),
    .instret         (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid    = 1'b0;
    wb_we       = 1'b0;
    wb_is_load  = 1'b0;
    wb_branch   = 1'b0;
    dmem_rvalid = 1'b0;
    stall_in    = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] r, input logic [31:0] e, input string tag);
    clear_wb();
    rs1_sel = r;
    #1;
    chk(tag, {32'd0, rs1_data}, {32'd0, e});
  endtask

  task automatic load_set(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
    wb_valid   = 1'b1;
    wb_we      = 1'b1;
    wb_is_load = 1'b1;
    wb_branch  = 1'b0;
    wb_funct3  = f3;
    wb_addr_lo = off;
    wb_rd      = rd;
  endtask

  task automatic alu_set(input logic [4:0] rd, input logic [31:0] res, input logic we, input logic br);
    wb_valid   = 1'b1;
    wb_we      = we;
    wb_is_load = 1'b0;
    wb_branch  = br;
    wb_rd      = rd;
    wb_result  = res;
  endtask

  initial begin
    reset = 1'b0;
    clear_wb();
    wb_rd = 5'd0; wb_funct3 = 3'd0; wb_addr_lo = 2'd0; wb_result = 32'd0;
    dmem_rdata = 32'd0; rs1_sel = 5'd0; rs2_sel = 5'd0;

    // Reset state
    stall_in = 1'b1;
    #1;
    chk("rst_stall_follows_stall_in", {63'd0, wb_stall}, 64'd1);
    chk("rst_squash", {63'd0, wb_squash}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    stall_in = 1'b0;
    #1;
    chk("rst_stall_low", {63'd0, wb_stall}, 64'd0);
    read_reg(5'd5, 32'd0, "rst_x5");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // 1: LW offset 0, response same cycle
    load_set(3'b010, 2'd0, 5'd5);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF; rs1_sel = 5'd5;
    #1;
    chk("t1_stall", {63'd0, wb_stall}, 64'd0);
    chk("t1_misaligned", {63'd0, load_misaligned}, 64'd0);
    chk("t1_fwd", {32'd0, rs1_data}, 64'hDEADBEEF);
    tick();
    read_reg(5'd5, 32'hDEADBEEF, "t1_x5");
    chk("t1_instret", instret, 64'd1);

    // 2: LB offset 3, response three cycles late
    load_set(3'b000, 2'd3, 5'd6);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h00000000; rs2_sel = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall_wait", {63'd0, wb_stall}, 64'd1);
      tick();
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80123456;
    #1;
    chk("t2_stall_release", {63'd0, wb_stall}, 64'd0);
    chk("t2_fwd", {32'd0, rs2_data}, 64'hFFFFFF80);
    tick();
    read_reg(5'd6, 32'hFFFFFF80, "t2_x6");
    chk("t2_instret", instret, 64'd2);

    // 3: response while stalled, parked in hold
    load_set(3'b010, 2'd0, 5'd10);
    stall_in = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("t3_stall_a", {63'd0, wb_stall}, 64'd1);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0BADBAD0;
    #1;
    chk("t3_stall_b", {63'd0, wb_stall}, 64'd1);
    tick();
    stall_in = 1'b0; rs1_sel = 5'd10;
    #1;
    chk("t3_stall_held_release", {63'd0, wb_stall}, 64'd0);
    chk("t3_fwd_held", {32'd0, rs1_data}, 64'hCAFEF00D);
    chk("t3_instret_before", instret, 64'd2);
    tick();
    read_reg(5'd10, 32'hCAFEF00D, "t3_x10");
    chk("t3_instret", instret, 64'd3);

    // 4: taken branch, three squashed slots (one holding a branch)
    alu_set(5'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("t4_squash_branch_slot", {63'd0, wb_squash}, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      alu_set(5'd7, 32'hA1 + i, 1'b1, (i == 1));
      rs1_sel = 5'd7;
      #1;
      chk("t4_squash_slot", {63'd0, wb_squash}, 64'd1);
      chk("t4_no_fwd_squashed", {32'd0, rs1_data}, 64'd0);
      tick();
    end
    alu_set(5'd7, 32'h11, 1'b1, 1'b0);
    rs1_sel = 5'd7;
    #1;
    chk("t4_squash_done", {63'd0, wb_squash}, 64'd0);
    chk("t4_fwd", {32'd0, rs1_data}, 64'h11);
    tick();
    read_reg(5'd7, 32'h11, "t4_x7");
    chk("t4_instret", instret, 64'd5);

    // 5: misaligned LH, then write to x0
    load_set(3'b001, 2'd1, 5'd8);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h12345678; rs1_sel = 5'd8;
    #1;
    chk("t5_misaligned", {63'd0, load_misaligned}, 64'd1);
    chk("t5_stall", {63'd0, wb_stall}, 64'd0);
    chk("t5_no_fwd", {32'd0, rs1_data}, 64'd0);
    tick();
    alu_set(5'd0, 32'h55, 1'b1, 1'b0);
    rs1_sel = 5'd0;
    #1;
    chk("t5_x0_fwd", {32'd0, rs1_data}, 64'd0);
    tick();
    read_reg(5'd8, 32'd0, "t5_x8");
    read_reg(5'd0, 32'd0, "t5_x0");
    chk("t5_instret", instret, 64'd7);

    // Extra formats: LHU, LH at offset 2, LD on a 32-bit datapath
    load_set(3'b101, 2'd2, 5'd11);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h9ABC1234;
    tick();
    load_set(3'b001, 2'd2, 5'd12);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h9ABC1234;
    tick();
    load_set(3'b011, 2'd0, 5'd5);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("x_ld32_misaligned", {63'd0, load_misaligned}, 64'd0);
    chk("x_ld32_stall", {63'd0, wb_stall}, 64'd0);
    tick();
    read_reg(5'd11, 32'h00009ABC, "x_lhu_x11");
    read_reg(5'd12, 32'hFFFF9ABC, "x_lh_x12");
    read_reg(5'd5, 32'h00000000, "x_ld32_x5");
    chk("x_instret", instret, 64'd10);

    // 6: reset while waiting, stray response afterwards, then forwarding
    load_set(3'b010, 2'd0, 5'd9);
    dmem_rvalid = 1'b0;
    #1;
    chk("t6_stall_enter", {63'd0, wb_stall}, 64'd1);
    tick();
    #1;
    chk("t6_stall_wait", {63'd0, wb_stall}, 64'd1);
    clear_wb();
    reset = 1'b0;
    #1;
    chk("t6_rst_instret", instret, 64'd0);
    chk("t6_rst_squash", {63'd0, wb_squash}, 64'd0);
    read_reg(5'd10, 32'd0, "t6_rst_x10");
    read_reg(5'd6, 32'd0, "t6_rst_x6");
    tick();
    reset = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h77777777;
    tick();
    load_set(3'b010, 2'd0, 5'd9);
    dmem_rvalid = 1'b0;
    #1;
    chk("t6_idle_after_stray", {63'd0, wb_stall}, 64'd1);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h00000099;
    #1;
    chk("t6_resp_stall", {63'd0, wb_stall}, 64'd0);
    tick();
    read_reg(5'd9, 32'h00000099, "t6_x9_load");
    chk("t6_instret", instret, 64'd1);
    alu_set(5'd9, 32'h1234, 1'b1, 1'b0);
    rs1_sel = 5'd9; rs2_sel = 5'd9;
    #1;
    chk("t6_fwd_rs1", {32'd0, rs1_data}, 64'h1234);
    chk("t6_fwd_rs2", {32'd0, rs2_data}, 64'h1234);
    tick();
    read_reg(5'd9, 32'h1234, "t6_x9_alu");
    chk("t6_instret_final", instret, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
